// File: rtl/ysyx_25040111_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_25040111_bus_arbiter
//
// Two-master, one-slave read/write arbiter. The I-cache refill port and the
// LSU share one memory-side beat interface (valid/ready per beat). Masters are
// granted round-robin, and a grant is held for a whole transaction
// (1..256 beats for the I-cache, always a single beat for the LSU). A watchdog
// aborts a transfer when the slave stops answering.
//
// Parameters
//   TMO_W    width of the watchdog counter; the transfer is aborted on the
//            2**TMO_W-1'th consecutive cycle without a beat (TMO_W >= 2)
//
// Ports
//   clock, reset                 clock, asynchronous active-low reset
//   chvalid/chready              I-cache request / per-beat done pulse
//   chaddr/chlen/chburst         I-cache beat address, beats-1, burst hint
//   chdata                       I-cache beat data, valid with chready
//   lsvalid/lsready              LSU request / done pulse
//   lsaddr/lswen/lswdata/lswmask LSU address, write enable, data, strobes
//   lsrdata                      LSU read data, valid with lsready
//   mvalid/mready                slave request / slave beat done
//   maddr/mlen/mburst            slave address, beats-1, burst
//   mwen/mwdata/mwmask           slave write enable, data, strobes
//   mrdata                       slave read data
//   bus_err/err_src              watchdog abort pulse, aborted master (1=LSU)
// ---------------------------------------------------------------------------
module ysyx_25040111_bus_arbiter #(
  parameter int TMO_W = 8
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        chvalid,
  output logic        chready,
  input  logic [31:0] chaddr,
  input  logic [7:0]  chlen,
  input  logic        chburst,
  output logic [31:0] chdata,

  input  logic        lsvalid,
  output logic        lsready,
  input  logic [31:0] lsaddr,
  input  logic        lswen,
  input  logic [31:0] lswdata,
  input  logic [3:0]  lswmask,
  output logic [31:0] lsrdata,

  output logic        mvalid,
  input  logic        mready,
  output logic [31:0] maddr,
  output logic [7:0]  mlen,
  output logic        mburst,
  output logic        mwen,
  output logic [31:0] mwdata,
  output logic [3:0]  mwmask,
  input  logic [31:0] mrdata,

  output logic        bus_err,
  output logic        err_src
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  // The cycle in which the watchdog still reads all-ones minus one while the
  // slave stalls again is the last tolerated one: that stall brings the count
  // of silent cycles to all-ones, so the abort is raised in that same cycle.
  localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state;
  logic             last_gnt;
  logic [7:0]       beat_cnt;
  logic [TMO_W-1:0] wdog;

  logic             gnt_i;
  logic             gnt_d;
  logic             beat;
  logic             stall;
  logic             last_beat;
  logic             abort;
  logic [7:0]       cur_len;

  // Transfer status decoded from the registered grant. Because every term
  // depends on mvalid or the state register, a reset forces all of them low
  // immediately, and a stray mready outside a grant is ignored.
  always_comb begin
    gnt_i     = (state == GNT_I);
    gnt_d     = (state == GNT_D);
    beat      = mvalid & mready;
    stall     = mvalid & ~mready;
    cur_len   = gnt_i ? chlen : 8'd0;
    last_beat = beat & (beat_cnt == cur_len);
    abort     = stall & (wdog == WDOG_LAST);
  end

  // Live pass-through of the granted master's request fields; the I-cache
  // advances chaddr itself after each beat. Everything is zero when idle.
  always_comb begin
    maddr  = 32'd0;
    mlen   = 8'd0;
    mburst = 1'b0;
    mwen   = 1'b0;
    mwdata = 32'd0;
    mwmask = 4'd0;
    if (gnt_i) begin
      maddr  = chaddr;
      mlen   = chlen;
      mburst = chburst;
    end else if (gnt_d) begin
      maddr  = lsaddr;
      mwen   = lswen;
      mwdata = lswdata;
      mwmask = lswmask;
    end
  end

  // Ready pulses go to the owner of the grant on every beat, and once more
  // on an abort so the requester is never left waiting; the abort beat
  // carries zero data since the slave returned nothing.
  always_comb begin
    chready = gnt_i & (beat | abort);
    lsready = gnt_d & (beat | abort);
    chdata  = (gnt_i & beat) ? mrdata : 32'd0;
    lsrdata = (gnt_d & beat) ? mrdata : 32'd0;
    bus_err = abort;
    err_src = abort & gnt_d;
  end

  // Arbitration FSM. A grant is decided only in IDLE, so after a transfer
  // there is always at least one idle cycle before the next grant. On a tie
  // the master that was not granted last wins; last_gnt resets to the
  // I-cache so the first tie goes to the LSU. A beat in the cycle the
  // watchdog would fire takes priority, which falls out of abort requiring
  // mready low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_gnt <= 1'b0;
      mvalid   <= 1'b0;
      beat_cnt <= 8'd0;
      wdog     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (chvalid && (!lsvalid || last_gnt)) begin
            state    <= GNT_I;
            last_gnt <= 1'b0;
            mvalid   <= 1'b1;
            beat_cnt <= 8'd0;
            wdog     <= '0;
          end else if (lsvalid) begin
            state    <= GNT_D;
            last_gnt <= 1'b1;
            mvalid   <= 1'b1;
            beat_cnt <= 8'd0;
            wdog     <= '0;
          end
        end
        GNT_I, GNT_D: begin
          if (last_beat || abort) begin
            state    <= IDLE;
            mvalid   <= 1'b0;
            beat_cnt <= 8'd0;
            wdog     <= '0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
            wdog     <= '0;
          end else if (stall) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          mvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule
